// File: rtl/fdn_pkg.sv
// -----------------------------------------------------------------------------
// fdn_pkg
//   Shared definitions for the elastic pipeline register bank (fdn_pipe).
//
//   Contents:
//     FDN_WIDTH_DEF  default data width in bits
//     FDN_DEPTH_DEF  default number of register stages
//     clog2_occ()    width needed to hold an occupancy count of 0..depth
// -----------------------------------------------------------------------------
package fdn_pkg;

    localparam int FDN_WIDTH_DEF = 4;
    localparam int FDN_DEPTH_DEF = 2;

    // Number of bits needed to represent every value 0..depth inclusive.
    // depth >= 1 always yields at least 1 bit.
    function automatic int clog2_occ(input int depth);
        int bits;
        bits = 0;
        while ((1 << bits) < (depth + 1)) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage : fdn_pkg

// File: rtl/fdn_pipe_stage.sv
// -----------------------------------------------------------------------------
// fdn_pipe_stage
//   One register stage of the elastic pipeline: a WIDTH-bit data register and
//   its valid bit.
//
//   Ports:
//     i_clk    clock, rising edge
//     i_rst_n  asynchronous active-low reset (data and valid cleared)
//     i_ce     clock enable; low holds data and valid
//     i_flush  synchronous clear of the valid bit (only while i_ce=1)
//     i_load   an entry arrives this cycle: capture i_d, set valid
//     i_leave  the held entry moves on this cycle: clear valid unless
//              i_load refills the stage in the same cycle
//     i_d      incoming data
//     o_d      registered data
//     o_v      registered valid
//
//   Priority while enabled: flush > load > leave.
// -----------------------------------------------------------------------------
module fdn_pipe_stage
    import fdn_pkg::*;
#(
    parameter int WIDTH = FDN_WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ce,
    input  logic             i_flush,
    input  logic             i_load,
    input  logic             i_leave,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_d,
    output logic             o_v
);

    logic [WIDTH-1:0] r_d;
    logic             r_v;

    // Data only changes when an entry actually lands here; a flush leaves the
    // old word in place because it is masked by the cleared valid bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_d <= '0;
        end else if (i_ce && !i_flush && i_load) begin
            r_d <= i_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v <= 1'b0;
        end else if (i_ce) begin
            if (i_flush) begin
                r_v <= 1'b0;
            end else if (i_load) begin
                r_v <= 1'b1;
            end else if (i_leave) begin
                r_v <= 1'b0;
            end
        end
    end

    assign o_d = r_d;
    assign o_v = r_v;

endmodule : fdn_pipe_stage

// File: rtl/fdn_pipe.sv
// -----------------------------------------------------------------------------
// fdn_pipe
//   Elastic pipeline register bank: DEPTH stages of WIDTH-bit data with
//   per-stage valid bits, valid/ready handshakes on both sides, bubble
//   collapsing, synchronous flush, clock enable and a registered occupancy
//   count.
//
//   Handshake: a word moves across an interface on a rising CK edge exactly
//   when valid and ready are both high in the cycle before that edge.
//   Input side: push = DV & DR. Output side: pop = QV & QR & CE & ~FLUSH.
//   DR never depends on DV; QV never depends on QR. A producer may hold DV
//   while DR is low; Q/QV hold while QR is low.
//
//   Ports:
//     CK     clock, rising edge
//     CLR_N  asynchronous active-low reset
//     CE     clock enable; low freezes all state and forces DR low
//     FLUSH  synchronous clear of all valids (only when CE=1)
//     D      input data
//     DV     input valid
//     DR     input ready
//     Q      output data (last stage)
//     QV     output valid (last stage)
//     QR     output ready from consumer
//     OCC    number of valid stages, 0..DEPTH
// -----------------------------------------------------------------------------
module fdn_pipe
    import fdn_pkg::*;
#(
    parameter int WIDTH = FDN_WIDTH_DEF,
    parameter int DEPTH = FDN_DEPTH_DEF,
    parameter int OCCW  = clog2_occ(DEPTH)
) (
    input  logic             CK,
    input  logic             CLR_N,
    input  logic             CE,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] D,
    input  logic             DV,
    output logic             DR,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    input  logic             QR,
    output logic [OCCW-1:0]  OCC
);

    // Per-stage state gathered from the stage instances.
    logic [DEPTH-1:0] w_v;
    logic [WIDTH-1:0] w_d [DEPTH];

    // Advance chain: w_mv[i] means stage i hands its entry on this cycle
    // (to stage i+1, or to the consumer for the last stage).
    logic [DEPTH-1:0] w_mv;
    logic [DEPTH-1:0] w_load;
    logic             w_pop;
    logic             w_push;

    // A flush cycle still shows QV, but the consumer's QR is not honoured.
    assign w_pop = w_v[DEPTH-1] & QR & CE & ~FLUSH;

    // Walk from the output back towards the input. A stage can accept when
    // the stage after it is empty or is itself emptying this cycle, which is
    // what lets bubbles collapse while the output is stalled.
    always_comb begin
        logic w_carry;
        w_mv            = '0;
        w_carry         = w_pop;
        w_mv[DEPTH-1]   = w_pop;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_carry = w_v[i] & (~w_v[i+1] | w_carry);
            w_mv[i] = w_carry;
        end
    end

    // The input stage is free when empty or when its entry moves on, so a
    // full pipe with QR=1 still takes one word per cycle.
    assign DR     = CE & ~FLUSH & (~w_v[0] | w_mv[0]);
    assign w_push = DV & DR;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_stage
            if (g == 0) begin : g_first
                assign w_load[g] = w_push;
            end else begin : g_rest
                assign w_load[g] = w_mv[g-1];
            end

            fdn_pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .i_clk   (CK),
                .i_rst_n (CLR_N),
                .i_ce    (CE),
                .i_flush (FLUSH),
                .i_load  (w_load[g]),
                .i_leave (w_mv[g]),
                .i_d     ((g == 0) ? D : w_d[(g == 0) ? 0 : g-1]),
                .o_d     (w_d[g]),
                .o_v     (w_v[g])
            );
        end
    endgenerate

    assign Q  = w_d[DEPTH-1];
    assign QV = w_v[DEPTH-1];

    // Occupancy tracks the number of valid stages. Push and pop in the same
    // cycle cancel; neither can happen when the count would leave 0..DEPTH
    // because push needs a free input slot and pop needs a valid output.
    logic [OCCW-1:0] r_occ;

    always_ff @(posedge CK or negedge CLR_N) begin
        if (!CLR_N) begin
            r_occ <= '0;
        end else if (CE) begin
            if (FLUSH) begin
                r_occ <= '0;
            end else if (w_push && !w_pop) begin
                r_occ <= r_occ + OCCW'(1);
            end else if (!w_push && w_pop) begin
                r_occ <= r_occ - OCCW'(1);
            end
        end
    end

    assign OCC = r_occ;

endmodule : fdn_pipe
